process_scheduler: RTL and testbench

Round-robin process scheduler that sequences the program counter between up to NPROC resident processes. Counts retired instructions of the running process, preempts it at quantum expiry, process end or I/O block, saves its resume PC, picks the next ready process and commands a PC load. Sits beside the PC, driving its load path instead of the fixed instruction-count check.

---
 rtl/process_scheduler_pkg.sv | 30 +++
 rtl/process_scheduler_if.sv | 36 +++
 rtl/process_scheduler_rr_arbiter.sv | 28 ++
 rtl/process_scheduler.sv | 145 ++++++++++++++
 tb/tb_process_scheduler.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/process_scheduler_pkg.sv
// Shared types for the round-robin process scheduler: slot states, FSM states,
// preemption causes and the PID width helper.
package sched_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_READY,
        SLOT_RUNNING,
        SLOT_BLOCKED
    } slot_state_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SAVE,
        ST_SELECT,
        ST_RESTORE
    } fsm_state_e;

    typedef enum logic [1:0] {
        CAUSE_END,
        CAUSE_IO,
        CAUSE_QUANTUM
    } cause_e;

    function automatic int pid_width(input int nproc);
        return (nproc > 2) ? $clog2(nproc) : 1;
    endfunction

endpackage

// File: rtl/process_scheduler_if.sv
// Bus between the scheduler and the core's PC / process-control logic.
// The slave modport is the scheduler side, master is the core side.
interface process_scheduler_if #(
    parameter int NPROC  = 4,
    parameter int ADDR_W = 32
) ();
    localparam int PID_W = sched_pkg::pid_width(NPROC);

    logic [ADDR_W-1:0] pc_in;
    logic              instr_retire;
    logic              proc_end;
    logic              io_block;
    logic [NPROC-1:0]  io_done;
    logic              create_valid;
    logic [PID_W-1:0]  create_pid;
    logic [ADDR_W-1:0] create_addr;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_addr;
    logic [PID_W-1:0]  cur_pid;
    logic              ctx_switch;
    logic              idle;
    logic [NPROC-1:0]  ready_mask;

    modport slave (
        input  pc_in, instr_retire, proc_end, io_block, io_done,
               create_valid, create_pid, create_addr,
        output pc_load, pc_load_addr, cur_pid, ctx_switch, idle, ready_mask
    );

    modport master (
        output pc_in, instr_retire, proc_end, io_block, io_done,
               create_valid, create_pid, create_addr,
        input  pc_load, pc_load_addr, cur_pid, ctx_switch, idle, ready_mask
    );

endinterface

// File: rtl/process_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or after 'start',
// wrapping around the slot index space.
module rr_arbiter #(
    parameter int NPROC = 4,
    parameter int PID_W = 2
) (
    input  logic [NPROC-1:0] req,
    input  logic [PID_W-1:0] start,
    output logic [PID_W-1:0] grant,
    output logic             valid
);

    logic [PID_W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NPROC; i++) begin
            idx = start + PID_W'(i);
            if (!valid && req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin process scheduler driving the PC load path.
// Define SCHED_IO_BLOCK_EN to enable the BLOCKED slot state, io_block and io_done.
module process_scheduler #(
    parameter int NPROC   = 4,
    parameter int QUANTUM = 43,
    parameter int ADDR_W  = 32
) (
    input logic                 CLK,
    input logic                 reset,
    process_scheduler_if.slave  bus
);
    import sched_pkg::*;

    localparam int PID_W = pid_width(NPROC);
    localparam int CNT_W = $clog2(QUANTUM);

    fsm_state_e        state_q, state_d;
    cause_e            cause_q, cause_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PID_W-1:0]  cur_pid_q, cur_pid_d;
    slot_state_e       slot_q [NPROC];
    slot_state_e       slot_d [NPROC];
    logic [ADDR_W-1:0] saved_pc_q [NPROC];
    logic [ADDR_W-1:0] saved_pc_d [NPROC];

    logic [NPROC-1:0]  ready_mask;
    logic [PID_W-1:0]  grant;
    logic              grant_valid;

    always_comb begin
        for (int i = 0; i < NPROC; i++) begin
            ready_mask[i] = (slot_q[i] == SLOT_READY);
        end
    end

    // Search starts just past the last-run slot, so a lone ready process is reselected.
    rr_arbiter #(.NPROC(NPROC), .PID_W(PID_W)) u_arb (
        .req   (ready_mask),
        .start (cur_pid_q + PID_W'(1)),
        .grant (grant),
        .valid (grant_valid)
    );

`ifndef SCHED_IO_BLOCK_EN
    logic unused_io;
    assign unused_io = ^{bus.io_block, bus.io_done};
`endif

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        count_d    = count_q;
        cur_pid_d  = cur_pid_q;
        slot_d     = slot_q;
        saved_pc_d = saved_pc_q;

        case (state_q)
            ST_IDLE: begin
                if (|ready_mask) state_d = ST_SELECT;
            end
            ST_RUN: begin
                if (bus.instr_retire) count_d = count_q + CNT_W'(1);
                if (bus.proc_end) begin
                    cause_d = CAUSE_END;
                    state_d = ST_SAVE;
                end
`ifdef SCHED_IO_BLOCK_EN
                else if (bus.io_block) begin
                    cause_d = CAUSE_IO;
                    state_d = ST_SAVE;
                end
`endif
                else if (bus.instr_retire && count_q == CNT_W'(QUANTUM - 1)) begin
                    cause_d = CAUSE_QUANTUM;
                    state_d = ST_SAVE;
                end
            end
            ST_SAVE: begin
                saved_pc_d[cur_pid_q] = bus.pc_in;
                case (cause_q)
                    CAUSE_END: slot_d[cur_pid_q] = SLOT_FREE;
`ifdef SCHED_IO_BLOCK_EN
                    // A wake arriving with the block itself must not be lost.
                    CAUSE_IO:  slot_d[cur_pid_q] = bus.io_done[cur_pid_q] ? SLOT_READY : SLOT_BLOCKED;
`endif
                    default:   slot_d[cur_pid_q] = SLOT_READY;
                endcase
                state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (grant_valid) begin
                    cur_pid_d = grant;
                    state_d   = ST_RESTORE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESTORE: begin
                slot_d[cur_pid_q] = SLOT_RUNNING;
                count_d           = '0;
                state_d           = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase

        // Creates and wakes only touch FREE/BLOCKED slots, never the one the FSM is editing.
        if (bus.create_valid && slot_q[bus.create_pid] == SLOT_FREE) begin
            slot_d[bus.create_pid]     = SLOT_READY;
            saved_pc_d[bus.create_pid] = bus.create_addr;
        end
`ifdef SCHED_IO_BLOCK_EN
        for (int i = 0; i < NPROC; i++) begin
            if (bus.io_done[i] && slot_q[i] == SLOT_BLOCKED) slot_d[i] = SLOT_READY;
        end
`endif
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_END;
            count_q   <= '0;
            cur_pid_q <= '0;
            for (int i = 0; i < NPROC; i++) begin
                slot_q[i]     <= SLOT_FREE;
                saved_pc_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            count_q    <= count_d;
            cur_pid_q  <= cur_pid_d;
            slot_q     <= slot_d;
            saved_pc_q <= saved_pc_d;
        end
    end

    assign bus.pc_load      = (state_q == ST_RESTORE);
    assign bus.ctx_switch   = (state_q == ST_RESTORE);
    assign bus.pc_load_addr = (state_q == ST_RESTORE) ? saved_pc_q[cur_pid_q] : '0;
    assign bus.cur_pid      = cur_pid_q;
    assign bus.idle         = (state_q == ST_IDLE);
    assign bus.ready_mask   = ready_mask;

endmodule

// File: tb/tb_process_scheduler.sv
// Directed testbench for process_scheduler; io tests follow SCHED_IO_BLOCK_EN.
module tb_process_scheduler;

    logic CLK;
    logic reset;
    int   tests_run;
    int   tests_failed;

    process_scheduler_if #(.NPROC(4), .ADDR_W(32)) bus ();

    process_scheduler #(.NPROC(4), .QUANTUM(43), .ADDR_W(32)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.pc_in        = '0;
        bus.instr_retire = 1'b0;
        bus.proc_end     = 1'b0;
        bus.io_block     = 1'b0;
        bus.io_done      = '0;
        bus.create_valid = 1'b0;
        bus.create_pid   = '0;
        bus.create_addr  = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        step();
        tests_run++; if (bus.pc_load !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_pc_load: got %b want 0", bus.pc_load); end
        tests_run++; if (bus.pc_load_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_addr: got %h want 0", bus.pc_load_addr); end
        tests_run++; if (bus.cur_pid !== 2'd0) begin tests_failed++; $display("[TB] FAIL rst_cur_pid: got %0d want 0", bus.cur_pid); end
        tests_run++; if (bus.ctx_switch !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_ctx: got %b want 0", bus.ctx_switch); end
        tests_run++; if (bus.idle !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_idle: got %b want 1", bus.idle); end
        tests_run++; if (bus.ready_mask !== 4'b0000) begin tests_failed++; $display("[TB] FAIL rst_ready: got %b want 0000", bus.ready_mask); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_two_procs();
        bus.create_valid = 1'b1; bus.create_pid = 2'd0; bus.create_addr = 32'h100;
        step();
        bus.create_valid = 1'b0;
        tests_run++; if (bus.ready_mask !== 4'b0001) begin tests_failed++; $display("[TB] FAIL tp_ready0: got %b want 0001", bus.ready_mask); end
        step();
        // pid1 created during SELECT: must not win this arbitration
        bus.create_valid = 1'b1; bus.create_pid = 2'd1; bus.create_addr = 32'h200;
        tests_run++; if (bus.pc_load !== 1'b0) begin tests_failed++; $display("[TB] FAIL tp_early_load: got %b want 0", bus.pc_load); end
        step();
        bus.create_valid = 1'b0;
        tests_run++; if (bus.pc_load !== 1'b1) begin tests_failed++; $display("[TB] FAIL tp_load0: got %b want 1", bus.pc_load); end
        tests_run++; if (bus.pc_load_addr !== 32'h100) begin tests_failed++; $display("[TB] FAIL tp_addr0: got %h want 100", bus.pc_load_addr); end
        tests_run++; if (bus.cur_pid !== 2'd0) begin tests_failed++; $display("[TB] FAIL tp_pid0: got %0d want 0", bus.cur_pid); end
        tests_run++; if (bus.idle !== 1'b0) begin tests_failed++; $display("[TB] FAIL tp_idle: got %b want 0", bus.idle); end
        step();
        tests_run++; if (bus.ready_mask !== 4'b0010) begin tests_failed++; $display("[TB] FAIL tp_ready_run: got %b want 0010", bus.ready_mask); end
        bus.instr_retire = 1'b1; bus.pc_in = 32'h1AC;
        repeat (43) step();
        bus.instr_retire = 1'b0;
        step();
        tests_run++; if (bus.pc_load !== 1'b0) begin tests_failed++; $display("[TB] FAIL tp_q_early: got %b want 0", bus.pc_load); end
        step();
        tests_run++; if (bus.pc_load !== 1'b1) begin tests_failed++; $display("[TB] FAIL tp_q_load: got %b want 1", bus.pc_load); end
        tests_run++; if (bus.pc_load_addr !== 32'h200) begin tests_failed++; $display("[TB] FAIL tp_addr1: got %h want 200", bus.pc_load_addr); end
        tests_run++; if (bus.cur_pid !== 2'd1) begin tests_failed++; $display("[TB] FAIL tp_pid1: got %0d want 1", bus.cur_pid); end
        step();
        bus.proc_end = 1'b1;
        step();
        bus.proc_end = 1'b0;
        step();
        step();
        tests_run++; if (bus.pc_load_addr !== 32'h1AC) begin tests_failed++; $display("[TB] FAIL tp_resume0: got %h want 1ac", bus.pc_load_addr); end
        tests_run++; if (bus.ready_mask !== 4'b0001) begin tests_failed++; $display("[TB] FAIL tp_ready_end: got %b want 0001", bus.ready_mask); end
        step();
    endtask

    task automatic test_proc_end_idle();
        bus.proc_end = 1'b1;
        step();
        bus.proc_end = 1'b0;
        step();
        tests_run++; if (bus.idle !== 1'b0) begin tests_failed++; $display("[TB] FAIL pe_idle_sel: got %b want 0", bus.idle); end
        step();
        tests_run++; if (bus.pc_load !== 1'b0) begin tests_failed++; $display("[TB] FAIL pe_no_load: got %b want 0", bus.pc_load); end
        tests_run++; if (bus.idle !== 1'b1) begin tests_failed++; $display("[TB] FAIL pe_idle: got %b want 1", bus.idle); end
        tests_run++; if (bus.ready_mask !== 4'b0000) begin tests_failed++; $display("[TB] FAIL pe_ready: got %b want 0000", bus.ready_mask); end
        step();
    endtask

    task automatic test_single_quantum();
        bus.create_valid = 1'b1; bus.create_pid = 2'd2; bus.create_addr = 32'h280;
        step();
        bus.create_valid = 1'b0;
        step();
        step();
        tests_run++; if (bus.pc_load_addr !== 32'h280 || bus.cur_pid !== 2'd2) begin tests_failed++; $display("[TB] FAIL sq_first: got %h/%0d want 280/2", bus.pc_load_addr, bus.cur_pid); end
        step();
        // create aimed at the running slot must be ignored
        bus.create_valid = 1'b1; bus.create_pid = 2'd2; bus.create_addr = 32'h999;
        step();
        bus.create_valid = 1'b0;
        tests_run++; if (bus.ready_mask !== 4'b0000) begin tests_failed++; $display("[TB] FAIL sq_create_run: got %b want 0000", bus.ready_mask); end
        bus.instr_retire = 1'b1; bus.pc_in = 32'h2AC;
        repeat (43) step();
        bus.instr_retire = 1'b0;
        step();
        step();
        tests_run++; if (bus.ctx_switch !== 1'b1) begin tests_failed++; $display("[TB] FAIL sq_ctx: got %b want 1", bus.ctx_switch); end
        tests_run++; if (bus.pc_load_addr !== 32'h2AC) begin tests_failed++; $display("[TB] FAIL sq_addr: got %h want 2ac", bus.pc_load_addr); end
        tests_run++; if (bus.cur_pid !== 2'd2) begin tests_failed++; $display("[TB] FAIL sq_pid: got %0d want 2", bus.cur_pid); end
        step();
        tests_run++; if (bus.ctx_switch !== 1'b0) begin tests_failed++; $display("[TB] FAIL sq_ctx_pulse: got %b want 0", bus.ctx_switch); end
        bus.proc_end = 1'b1;
        step();
        bus.proc_end = 1'b0;
        repeat (3) step();
    endtask

`ifdef SCHED_IO_BLOCK_EN
    task automatic test_io_block();
        bus.create_valid = 1'b1; bus.create_pid = 2'd1; bus.create_addr = 32'h400;
        step();
        bus.create_valid = 1'b0;
        step();
        bus.create_valid = 1'b1; bus.create_pid = 2'd0; bus.create_addr = 32'h300;
        step();
        bus.create_valid = 1'b0;
        tests_run++; if (bus.pc_load_addr !== 32'h400 || bus.cur_pid !== 2'd1) begin tests_failed++; $display("[TB] FAIL io_first: got %h/%0d want 400/1", bus.pc_load_addr, bus.cur_pid); end
        step();
        bus.io_block = 1'b1; bus.pc_in = 32'h240;
        step();
        bus.io_block = 1'b0;
        step();
        tests_run++; if (bus.ready_mask !== 4'b0001) begin tests_failed++; $display("[TB] FAIL io_blocked_mask: got %b want 0001", bus.ready_mask); end
        step();
        tests_run++; if (bus.pc_load_addr !== 32'h300 || bus.cur_pid !== 2'd0) begin tests_failed++; $display("[TB] FAIL io_switch: got %h/%0d want 300/0", bus.pc_load_addr, bus.cur_pid); end
        step();
        bus.io_done = 4'b0010;
        step();
        bus.io_done = 4'b0000;
        tests_run++; if (bus.ready_mask !== 4'b0010) begin tests_failed++; $display("[TB] FAIL io_wake: got %b want 0010", bus.ready_mask); end
        bus.proc_end = 1'b1;
        step();
        bus.proc_end = 1'b0;
        step();
        step();
        tests_run++; if (bus.pc_load_addr !== 32'h240 || bus.cur_pid !== 2'd1) begin tests_failed++; $display("[TB] FAIL io_resume: got %h/%0d want 240/1", bus.pc_load_addr, bus.cur_pid); end
        step();
        bus.proc_end = 1'b1;
        step();
        bus.proc_end = 1'b0;
        repeat (3) step();
    endtask
`else
    task automatic test_io_ignored();
        bus.create_valid = 1'b1; bus.create_pid = 2'd1; bus.create_addr = 32'h400;
        step();
        bus.create_valid = 1'b0;
        step();
        step();
        tests_run++; if (bus.pc_load_addr !== 32'h400 || bus.cur_pid !== 2'd1) begin tests_failed++; $display("[TB] FAIL ioi_first: got %h/%0d want 400/1", bus.pc_load_addr, bus.cur_pid); end
        step();
        bus.io_block = 1'b1; bus.io_done = 4'b1111;
        step();
        bus.io_block = 1'b0; bus.io_done = 4'b0000;
        step();
        step();
        tests_run++; if (bus.pc_load !== 1'b0 || bus.idle !== 1'b0) begin tests_failed++; $display("[TB] FAIL ioi_ignored: got load=%b idle=%b want 0/0", bus.pc_load, bus.idle); end
        tests_run++; if (bus.ready_mask !== 4'b0000) begin tests_failed++; $display("[TB] FAIL ioi_mask: got %b want 0000", bus.ready_mask); end
        bus.proc_end = 1'b1;
        step();
        bus.proc_end = 1'b0;
        repeat (3) step();
    endtask
`endif

    task automatic test_reset_mid();
        bus.create_valid = 1'b1; bus.create_pid = 2'd3; bus.create_addr = 32'h500;
        step();
        bus.create_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        tests_run++; if (bus.idle !== 1'b1 || bus.pc_load !== 1'b0) begin tests_failed++; $display("[TB] FAIL rm_async: got idle=%b load=%b want 1/0", bus.idle, bus.pc_load); end
        tests_run++; if (bus.ready_mask !== 4'b0000 || bus.cur_pid !== 2'd0) begin tests_failed++; $display("[TB] FAIL rm_state: got mask=%b pid=%0d want 0000/0", bus.ready_mask, bus.cur_pid); end
        step();
        reset = 1'b1;
        step();
        step();
        tests_run++; if (bus.pc_load !== 1'b0 || bus.idle !== 1'b1) begin tests_failed++; $display("[TB] FAIL rm_no_load: got load=%b idle=%b want 0/1", bus.pc_load, bus.idle); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        clear_inputs();
        test_reset();
        test_two_procs();
        test_proc_end_idle();
        test_single_quantum();
`ifdef SCHED_IO_BLOCK_EN
        test_io_block();
`else
        test_io_ignored();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
